sme_rf_wr_arb: RTL

- Write-port arbiter and scheduler for the SME share register files (shares 1..SMAX-1).
- Shares the single write port of each share regfile between two sources:
  - bank load writes from the host load path;
  - pipeline writeback of all shares of rd.
- Holds one pending writeback, grants bank writes with priority, bounds writeback starvation, and drives registered per-regfile write controls.

---
 rtl/sme_rf_wr_arb.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sme_rf_wr_arb.sv
// ----------------------------------------------------------------------------
// sme_rf_wr_arb
//   Write-port arbiter/scheduler for the SME share register files
//   (shares 1..SMAX-1; share 0 is the GPR file and is not driven here).
//   Two sources compete for the single write port of each share regfile:
//     - bank load writes from the host load path (one share per write)
//     - pipeline writeback of all shares of rd (every share at once)
//   Bank writes have priority. One writeback can be held pending, and a
//   starvation counter bounds how long it waits. All regfile write
//   controls are registered.
//
// Optional feature (macro SME_WR_ARB_SCRUB_EN):
//   Adds scrub_req/scrub_busy. On request, pending writebacks drain, then
//   every address 0..15 in every share regfile is written with zero.
//
// Ports:
//   g_clk, g_resetn   clock, asynchronous active-low reset
//   bank_wen/ready    bank write handshake
//   bank_sel          target share index (legal 1..SMAX-1)
//   bank_waddr/wdata  bank write address/data
//   bank_err          one-cycle pulse: accepted bank write had illegal sel
//   wb_valid/ready    writeback handshake
//   wb_addr/wb_data   rd address, shares 1..SMAX-1 packed (share k = lane k-1)
//   rf_wen            per-regfile write enable (bit k-1 drives share k)
//   rf_addr/rf_wdata  registered write address, per-lane write data
//   scrub_req/busy    (SME_WR_ARB_SCRUB_EN only) scrub request / in progress
// ----------------------------------------------------------------------------
module sme_rf_wr_arb #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned SMAX         = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                       g_clk,
  input  logic                       g_resetn,
  input  logic                       bank_wen,
  output logic                       bank_ready,
  input  logic [3:0]                 bank_sel,
  input  logic [3:0]                 bank_waddr,
  input  logic [XLEN-1:0]            bank_wdata,
  output logic                       bank_err,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [3:0]                 wb_addr,
  input  logic [(SMAX-1)*XLEN-1:0]   wb_data,
  output logic [SMAX-2:0]            rf_wen,
  output logic [3:0]                 rf_addr,
  output logic [(SMAX-1)*XLEN-1:0]   rf_wdata
`ifdef SME_WR_ARB_SCRUB_EN
  ,
  input  logic                       scrub_req,
  output logic                       scrub_busy
`endif
);

  localparam int unsigned NL = SMAX - 1;
  localparam int unsigned DW = NL * XLEN;
  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  // Writeback holding entry
  logic          r_buf_v;
  logic [3:0]    r_buf_addr;
  logic [DW-1:0] r_buf_data;

  logic [CW-1:0] r_starve_cnt;

  // Registered regfile write controls
  logic [NL-1:0] r_rf_wen;
  logic [3:0]    r_rf_addr;
  logic [DW-1:0] r_rf_wdata;
  logic          r_bank_err;

  logic          w_run;
  logic          w_scrub_hold;
  logic          w_force_wb;
  logic          w_bank_hs;
  logic          w_wb_hs;
  logic          w_grant_bank;
  logic          w_grant_wb;
  logic          w_sel_legal;

  logic [NL-1:0] w_wen_nxt;
  logic [3:0]    w_addr_nxt;
  logic [DW-1:0] w_wdata_nxt;
  logic          w_err_nxt;

`ifdef SME_WR_ARB_SCRUB_EN
  typedef enum logic {
    ST_RUN,
    ST_SCRUB
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_scrub_addr;

  assign w_run        = (r_state == ST_RUN);
  // Holding wb_ready low while a scrub is requested lets the buffer drain
  assign w_scrub_hold = scrub_req;
  assign scrub_busy   = (r_state == ST_SCRUB);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state      <= ST_RUN;
      r_scrub_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_SCRUB) begin
        r_scrub_addr <= r_scrub_addr + 4'd1;
      end else begin
        r_scrub_addr <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (scrub_req && !r_buf_v) begin
          w_state_nxt = ST_SCRUB;
        end
      end
      ST_SCRUB: begin
        if (r_scrub_addr == 4'hF) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end
`else
  assign w_run        = 1'b1;
  assign w_scrub_hold = 1'b0;
`endif

  // Handshakes and grant selection (at most one grant per cycle)
  assign w_force_wb   = r_buf_v && (r_starve_cnt == CW'(STARVE_LIMIT));
  assign bank_ready   = w_run && !w_force_wb;
  assign w_bank_hs    = bank_wen && bank_ready;
  assign w_grant_bank = w_bank_hs;
  assign w_grant_wb   = w_run && !w_bank_hs && r_buf_v;
  // The entry can accept a new writeback in the same cycle it drains
  assign wb_ready     = w_run && !w_scrub_hold && (!r_buf_v || w_grant_wb);
  assign w_wb_hs      = wb_valid && wb_ready;

  assign w_sel_legal  = (bank_sel != 4'd0) && ({28'd0, bank_sel} < SMAX);

  // Writeback buffer
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_buf_v    <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
    end else begin
      if (w_wb_hs) begin
        r_buf_v    <= 1'b1;
        r_buf_addr <= wb_addr;
        r_buf_data <= wb_data;
      end else if (w_grant_wb) begin
        r_buf_v    <= 1'b0;
      end
    end
  end

  // Starvation counter: counts bank grants taken while a writeback waits
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_starve_cnt <= '0;
    end else begin
      if (!r_buf_v || w_grant_wb) begin
        r_starve_cnt <= '0;
      end else if (w_grant_bank && (r_starve_cnt != CW'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  // Next-state of the registered write port
  always_comb begin
    w_wen_nxt   = '0;
    w_addr_nxt  = r_rf_addr;
    w_wdata_nxt = r_rf_wdata;
    w_err_nxt   = 1'b0;
`ifdef SME_WR_ARB_SCRUB_EN
    if (r_state == ST_SCRUB) begin
      w_wen_nxt   = '1;
      w_addr_nxt  = r_scrub_addr;
      w_wdata_nxt = '0;
    end else
`endif
    if (w_grant_bank) begin
      if (w_sel_legal) begin
        w_addr_nxt  = bank_waddr;
        w_wdata_nxt = '0;
        for (int unsigned k = 0; k < NL; k++) begin
          if ((k + 1) == {28'd0, bank_sel}) begin
            w_wen_nxt[k]                = 1'b1;
            w_wdata_nxt[k*XLEN +: XLEN] = bank_wdata;
          end
        end
      end else begin
        // Illegal share: drop the write but still complete the handshake
        w_err_nxt = 1'b1;
      end
    end else if (w_grant_wb) begin
      w_wen_nxt   = '1;
      w_addr_nxt  = r_buf_addr;
      w_wdata_nxt = r_buf_data;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_rf_wen   <= '0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
      r_bank_err <= 1'b0;
    end else begin
      r_rf_wen   <= w_wen_nxt;
      r_rf_addr  <= w_addr_nxt;
      r_rf_wdata <= w_wdata_nxt;
      r_bank_err <= w_err_nxt;
    end
  end

  assign rf_wen   = r_rf_wen;
  assign rf_addr  = r_rf_addr;
  assign rf_wdata = r_rf_wdata;
  assign bank_err = r_bank_err;

endmodule
